// File: rtl/qr_pkg.sv
// Shared types and default phase lengths for the word-line sequencer.
// Dead-time phases are controlled by QR_SEQ_DEADTIME_EN.
package qr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_DEAD0,
        ST_DRIVE,
        ST_DEAD1,
        ST_SHARE,
        ST_SENSE
    } qr_seq_state_t;

    localparam int QR_RST_CYCLES = 2;
    localparam int QR_DRV_CYCLES = 4;
    localparam int QR_SHR_CYCLES = 2;

    function automatic int qr_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qr_rowsel_reg.sv
// Row-select register with true and complement outputs.
// Reset leaves the true side low and the complement side high.
module qr_rowsel_reg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            qb <= '1;
        end else begin
            q  <= d;
            qb <= ~d;
        end
    end

endmodule

// File: rtl/qr_wl_sequencer.sv
// Word-line phase sequencer for the charge-redistribution CIM array.
// Define QR_SEQ_DEADTIME_EN to insert break-before-make DEAD0/DEAD1 phases.
module qr_wl_sequencer
    import qr_pkg::*;
#(
    parameter int SRAM_ROWS  = 128,
    parameter int RST_CYCLES = QR_RST_CYCLES,
    parameter int DRV_CYCLES = QR_DRV_CYCLES,
    parameter int SHR_CYCLES = QR_SHR_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [SRAM_ROWS-1:0] IN_DATA,
    input  logic [SRAM_ROWS-1:0] IN_MASK,
    input  logic                 IN_NEG,
    output logic [SRAM_ROWS-1:0] VDR_SEL,
    output logic [SRAM_ROWS-1:0] VSS_SEL,
    output logic [SRAM_ROWS-1:0] VRST_SEL,
    output logic [SRAM_ROWS-1:0] VDR_SELB,
    output logic [SRAM_ROWS-1:0] VSS_SELB,
    output logic [SRAM_ROWS-1:0] VRST_SELB,
    output logic                 NF,
    output logic                 NFB,
    output logic                 M2A,
    output logic                 M2AB,
    output logic                 R2A,
    output logic                 R2AB,
    output logic                 PCH,
    output logic                 SAEN,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int MAXC = qr_max3(RST_CYCLES, DRV_CYCLES, SHR_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    qr_seq_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic          fire;

    logic [SRAM_ROWS-1:0] data_q, mask_q;
    logic                 neg_q;

    logic [SRAM_ROWS-1:0] vdr_d, vss_d, vrst_d;
    logic nf_d, m2a_d, r2a_d, pch_d, saen_d, busy_d, done_d;

    assign IN_READY = (state == ST_IDLE) && !RST;
    assign fire     = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data_q <= '0;
            mask_q <= '0;
            neg_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (state != nxt) begin
                unique case (nxt)
                    ST_RESET: cnt <= CW'(RST_CYCLES - 1);
                    ST_DRIVE: cnt <= CW'(DRV_CYCLES - 1);
                    ST_SHARE: cnt <= CW'(SHR_CYCLES - 1);
                    default:  cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (fire) begin
                data_q <= IN_DATA;
                mask_q <= IN_MASK;
                neg_q  <= IN_NEG;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (fire) nxt = ST_RESET;
`ifdef QR_SEQ_DEADTIME_EN
            ST_RESET: if (cnt == '0) nxt = ST_DEAD0;
            ST_DRIVE: if (cnt == '0) nxt = ST_DEAD1;
`else
            ST_RESET: if (cnt == '0) nxt = ST_DRIVE;
            ST_DRIVE: if (cnt == '0) nxt = ST_SHARE;
`endif
            ST_DEAD0: nxt = ST_DRIVE;
            ST_DEAD1: nxt = ST_SHARE;
            ST_SHARE: if (cnt == '0) nxt = ST_SENSE;
            ST_SENSE: nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Decode the upcoming state so outputs switch on the same edge as state.
    always_comb begin
        vdr_d  = '0;
        vss_d  = '0;
        vrst_d = '0;
        nf_d   = 1'b0;
        m2a_d  = 1'b0;
        r2a_d  = 1'b0;
        pch_d  = 1'b0;
        saen_d = 1'b0;
        busy_d = (nxt != ST_IDLE);
        done_d = (state == ST_SENSE) && (nxt == ST_IDLE);
        unique case (nxt)
            ST_RESET: begin
                vrst_d = '1;
                pch_d  = 1'b1;
            end
            ST_DRIVE: begin
                vdr_d = data_q & mask_q;
                vss_d = ~data_q & mask_q;
                nf_d  = neg_q;
            end
            ST_SHARE: begin
                m2a_d = 1'b1;
                r2a_d = 1'b1;
            end
            ST_SENSE: saen_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            NF   <= 1'b0;
            NFB  <= 1'b1;
            M2A  <= 1'b0;
            M2AB <= 1'b1;
            R2A  <= 1'b0;
            R2AB <= 1'b1;
            PCH  <= 1'b0;
            SAEN <= 1'b0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
        end else begin
            NF   <= nf_d;
            NFB  <= ~nf_d;
            M2A  <= m2a_d;
            M2AB <= ~m2a_d;
            R2A  <= r2a_d;
            R2AB <= ~r2a_d;
            PCH  <= pch_d;
            SAEN <= saen_d;
            BUSY <= busy_d;
            DONE <= done_d;
        end
    end

    qr_rowsel_reg #(.W(SRAM_ROWS)) u_vdr (
        .clk (CLK),
        .rst (RST),
        .d   (vdr_d),
        .q   (VDR_SEL),
        .qb  (VDR_SELB)
    );

    qr_rowsel_reg #(.W(SRAM_ROWS)) u_vss (
        .clk (CLK),
        .rst (RST),
        .d   (vss_d),
        .q   (VSS_SEL),
        .qb  (VSS_SELB)
    );

    qr_rowsel_reg #(.W(SRAM_ROWS)) u_vrst (
        .clk (CLK),
        .rst (RST),
        .d   (vrst_d),
        .q   (VRST_SEL),
        .qb  (VRST_SELB)
    );

endmodule

// File: doc/qr_wl_sequencer.md
# qr_wl_sequencer

Cycle-accurate word-line phase sequencer for the charge-redistribution compute-in-memory macro. It accepts one SRAM_ROWS-wide activation vector per operation over a valid/ready handshake. It then drives the reset, drive, charge-share and sense phases on the row select lines, complements and ADC switches that the analog array consumes. It replaces bench-generated select waveforms with synthesizable control sitting directly upstream of the array.

## Interface
- SRAM_ROWS, 128, number of word-line rows
- RST_CYCLES, 2, cycles in RESET phase (≥1)
- DRV_CYCLES, 4, cycles in DRIVE phase (≥1)
- SHR_CYCLES, 2, cycles in SHARE phase (≥1)

- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  activation vector valid
- IN_READY  out  1  sequencer can accept a vector
- IN_DATA  in  SRAM_ROWS  activation bits (1 → VDR, 0 → VSS)
- IN_MASK  in  SRAM_ROWS  row enable; 0 = row driven neither side
- IN_NEG  in  1  negative-input operation; drives NF
- VDR_SEL, VSS_SEL, VRST_SEL  out  SRAM_ROWS each  row selects
- VDR_SELB, VSS_SELB, VRST_SELB  out  SRAM_ROWS each  exact complements
- NF/NFB, M2A/M2AB, R2A/R2AB  out  1 each  array switch controls and complements
- PCH  out  1  precharge
- SAEN  out  1  sense-amp enable
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RESET, DEAD0, DRIVE, DEAD1, SHARE, SENSE.
- IN_READY = (state==IDLE) && !RST. Handshake fires on the edge where IN_VALID && IN_READY. IN_DATA, IN_MASK and IN_NEG are latched there. Inputs are ignored otherwise.
- IDLE → RESET on handshake. RESET → DEAD0 → DRIVE → DEAD1 → SHARE → SENSE → IDLE.
- RESET, DRIVE and SHARE each last their parameter count, tracked by one down-counter sized $clog2(max param + 1).
- DEAD0, DEAD1 and SENSE last 1 cycle each.
- Outputs per state, all others deasserted:
  - RESET: VRST_SEL = all ones, PCH = 1.
  - DEAD0/DEAD1: all selects 0.
  - DRIVE: VDR_SEL = data & mask; VSS_SEL = ~data & mask; NF = neg.
  - SHARE: M2A = 1, R2A = 1.
  - SENSE: SAEN = 1.
- VDR_SEL and VSS_SEL are never both 1 on any row in any cycle.
- BUSY = state != IDLE. DONE pulses in the first IDLE cycle after SENSE. A new handshake is legal in that same cycle.

## Timing
- All outputs are registered: the decode of the next state is registered, so outputs change on the same edge as the state.
- Every *B output is registered alongside its true output and equals its bitwise inverse in every cycle, including reset.
- Reset values: all *_SEL = 0, all *_SELB = all ones, NF/M2A/R2A/PCH/SAEN/BUSY/DONE = 0, NFB/M2AB/R2AB = 1, state = IDLE.
- Defaults with dead-time (handshake edge = cycle 0): RESET 1–2, DEAD0 3, DRIVE 4–7, DEAD1 8, SHARE 9–10, SENSE 11, DONE at 12.
- Defaults without dead-time: RESET 1–2, DRIVE 3–6, SHARE 7–8, SENSE 9, DONE at 10.
- RST asserted in any state: at the next edge, force reset values and return to IDLE. No DONE pulse is issued for the aborted operation.
- IN_VALID held high continuously gives back-to-back operations with no IDLE bubble beyond the DONE cycle.

## Configuration
- QR_SEQ_DEADTIME_EN defined: DEAD0 and DEAD1 are present; every select transition passes through an all-zero cycle (break-before-make).
- Not defined: DEAD0 and DEAD1 are removed from the state machine and the DRIVE selects switch directly after RESET / into SHARE. Total latency drops by 2 cycles.

## Structure
- Shared package qr_pkg holds:
  - the state enum qr_seq_state_t;
  - default cycle-count localparams QR_RST_CYCLES, QR_DRV_CYCLES, QR_SHR_CYCLES.
- Sub-module qr_rowsel_reg: a SRAM_ROWS-wide register that loads a value and emits true and complement outputs with reset value 0 / all ones. Instantiate it three times (VDR, VSS, VRST).

## Test plan
- Reset, then IN_DATA=0x…0005, IN_MASK=all ones, IN_NEG=0:
  - VRST_SEL all ones in cycles 1–2;
  - VDR_SEL=0x…0005 and VSS_SEL=~0x…0005 in DRIVE;
  - SAEN high only in cycle 11;
  - DONE high only in cycle 12.
- IN_MASK=0x…00FF, IN_DATA=0x…0F0F: in DRIVE, rows 8+ have VDR_SEL=VSS_SEL=0; VDR_SEL=0x0F and VSS_SEL=0xF0 on rows 0–7.
- IN_NEG=1: NF=1 and NFB=0 exactly during DRIVE cycles; NF=0 elsewhere.
- RST pulsed in cycle 5 (mid-DRIVE): next cycle all outputs are at reset values, IN_READY=1 after RST drops, no DONE pulse.
- IN_VALID held high for 3 vectors: handshakes in cycles 0, 12 and 24; DONE in cycles 12, 24 and 36; every cycle satisfies *B == ~true and no row has VDR_SEL & VSS_SEL.
- Rebuild without QR_SEQ_DEADTIME_EN and repeat the first scenario: SAEN in cycle 9, DONE in cycle 10.
